// File: rtl/seqdiv_8b_pkg.sv
// seqdiv_8b_pkg
//   Shared definitions for the 8-bit significand divider.
//   - state_t   : controller states (IDLE, BUSY, DONE)
//   - DIV_ITERS : quotient bits resolved per division (one per clock)
//   - RES_W     : width of the normalized result (8 significand + R + S)
//   - CNT_W     : width of the iteration counter
package seqdiv_8b_pkg;

    localparam int DIV_ITERS = 11;
    localparam int RES_W     = 10;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seqdiv_8b_if.sv
// seqdiv_8b_if
//   Operand/result bus of the divider.
//   Handshake: a transfer happens on a rising clk edge where valid && ready.
//   in_valid/a/b come from the producer, in_ready from the divider; a pair
//   is taken on the first edge with in_valid && in_ready. out_valid and the
//   result fields come from the divider and stay stable until the edge with
//   out_valid && out_ready, which completes the transfer.
//   - master : producer/consumer side (testbench or upstream logic)
//   - slave  : divider side
interface seqdiv_8b_if;
    import seqdiv_8b_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [7:0]       a;
    logic [7:0]       b;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] result;
    logic             quot_ge1;
    logic             round_loss;
    logic             err;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, quot_ge1, round_loss, err
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, quot_ge1, round_loss, err
    );

endinterface

// File: rtl/seqdiv_8b_div_step.sv
// seqdiv_8b_div_step
//   One radix-2 restoring division step (purely combinational).
//   Ports:
//     rem_i : current partial remainder (always < 2*div_i)
//     div_i : divisor
//     q_o   : resolved quotient bit (rem_i >= div_i)
//     rem_o : partial remainder after the conditional subtract (< div_i)
module seqdiv_8b_div_step (
    input  logic [8:0] rem_i,
    input  logic [7:0] div_i,
    output logic       q_o,
    output logic [8:0] rem_o
);

    logic [8:0] diff;

    always_comb begin
        diff  = rem_i - {1'b0, div_i};
        q_o   = (rem_i >= {1'b0, div_i});
        // Restore (keep the old remainder) when the subtract would go negative.
        rem_o = q_o ? diff : rem_i;
    end

endmodule

// File: rtl/seqdiv_8b.sv
// seqdiv_8b
//   Sequential BF16 significand divider: Q = floor((a<<10)/b), one quotient
//   bit per clock, MSB first, then normalized to a 10-bit result with a
//   sticky round_loss flag.
//   Ports:
//     clk       : clock, rising edge
//     rst       : synchronous active-high reset
//     bus       : operand/result handshake bus (slave side)
//     dbg_state : current controller state
module seqdiv_8b
    import seqdiv_8b_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    seqdiv_8b_if.slave    bus,
    output state_t        dbg_state
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [8:0]         rem_q, rem_d;
    logic [7:0]         div_q, div_d;
    logic [RES_W-1:0]   quo_q, quo_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               quot_ge1_q, quot_ge1_d;
    logic               round_loss_q, round_loss_d;
    logic               err_q, err_d;

    logic               in_ready;
    logic               step_q;
    logic [8:0]         step_rem;
    logic [DIV_ITERS-1:0] quo_full;

    seqdiv_8b_div_step u_div_step (
        .rem_i (rem_q),
        .div_i (div_q),
        .q_o   (step_q),
        .rem_o (step_rem)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rem_d        = rem_q;
        div_d        = div_q;
        quo_d        = quo_q;
        result_d     = result_q;
        quot_ge1_d   = quot_ge1_q;
        round_loss_d = round_loss_q;
        err_d        = err_q;

        // DONE accepts a new pair only on the same edge the result leaves.
        in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
        quo_full = {quo_q, step_q};

        case (state_q)
            IDLE, DONE: begin
                if (in_ready) begin
                    if (bus.in_valid) begin
                        if (bus.b[7]) begin
                            state_d = BUSY;
                            cnt_d   = CNT_W'(DIV_ITERS - 1);
                            // a < 2*b for a normalized b, so Q fits in 11 bits
                            // and a itself is the first partial remainder.
                            rem_d   = {1'b0, bus.a};
                            div_d   = bus.b;
                            quo_d   = '0;
                        end else begin
                            state_d      = DONE;
                            result_d     = '1;
                            quot_ge1_d   = 1'b1;
                            round_loss_d = 1'b0;
                            err_d        = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            BUSY: begin
                quo_d = {quo_q[RES_W-2:0], step_q};
                rem_d = step_rem << 1;
                if (cnt_q == '0) begin
                    // Last bit resolved this edge: step_rem is the final remainder.
                    state_d    = DONE;
                    err_d      = 1'b0;
                    quot_ge1_d = quo_full[DIV_ITERS-1];
                    if (quo_full[DIV_ITERS-1]) begin
                        result_d     = quo_full[DIV_ITERS-1:1];
                        round_loss_d = quo_full[0] | (step_rem != '0);
                    end else begin
                        result_d     = quo_full[RES_W-1:0];
                        round_loss_d = (step_rem != '0);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rem_q        <= '0;
            div_q        <= '0;
            quo_q        <= '0;
            result_q     <= '0;
            quot_ge1_q   <= 1'b0;
            round_loss_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rem_q        <= rem_d;
            div_q        <= div_d;
            quo_q        <= quo_d;
            result_q     <= result_d;
            quot_ge1_q   <= quot_ge1_d;
            round_loss_q <= round_loss_d;
            err_q        <= err_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = (state_q == DONE);
    assign bus.result     = result_q;
    assign bus.quot_ge1   = quot_ge1_q;
    assign bus.round_loss = round_loss_q;
    assign bus.err        = err_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_seqdiv_8b.sv
// tb_seqdiv_8b
//   Self-checking bench for seqdiv_8b. Inputs change on the falling edge,
//   outputs are sampled on the falling edge. Expected results are
//   {err, round_loss, quot_ge1, result} words held in exp_q.
module tb_seqdiv_8b;
    import seqdiv_8b_pkg::*;

    logic   clk = 1'b0;
    logic   rst;
    state_t dbg_state;

    seqdiv_8b_if bus ();

    seqdiv_8b dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [12:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    // Reference: direct integer division, no bit-serial modelling.
    function automatic logic [12:0] model(input logic [7:0] a, input logic [7:0] b);
        int unsigned num, q, r;
        logic [10:0] qq;
        if (b[7] == 1'b0) return {1'b1, 1'b0, 1'b1, 10'h3FF};
        num = a * 1024;
        q   = num / b;
        r   = num % b;
        qq  = q[10:0];
        if (qq[10]) return {1'b0, qq[0] | (r != 0), 1'b1, qq[10:1]};
        return {1'b0, (r != 0), 1'b0, qq[9:0]};
    endfunction

    function automatic logic [12:0] obs_now();
        return {bus.err, bus.round_loss, bus.quot_ge1, bus.result};
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic drive_pair(input logic [7:0] a, input logic [7:0] b,
                              input logic [12:0] exp, input bit push);
        int w = 0;
        while (bus.in_ready !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (w >= 40) begin
            n_vec++;
            n_err++;
            $display("FAIL drive_timeout: in_ready=%b, required 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        if (push) exp_q.push_back(exp);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Waits (bounded) for out_valid; cycles = edges since the acceptance edge.
    // With noise set, in_valid/a/b toggle while the divider is busy.
    task automatic collect(input bit noise, output logic [12:0] obs, output int cycles);
        cycles = 0;
        while (bus.out_valid !== 1'b1 && cycles < 40) begin
            if (noise) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.a        = 8'($urandom_range(0, 255));
                bus.b        = 8'($urandom_range(0, 255));
            end
            @(negedge clk);
            cycles++;
        end
        bus.in_valid = 1'b0;
        obs = obs_now();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({bus.out_valid, bus.in_ready, obs_now()} !== {1'b0, 1'b1, 13'h0}) begin
            n_err++;
            $display("FAIL reset_outputs: got %h, expected %h",
                     {bus.out_valid, bus.in_ready, obs_now()}, {1'b0, 1'b1, 13'h0});
        end
        n_vec++;
        if (dbg_state !== IDLE) begin
            n_err++;
            $display("FAIL reset_state: got %0d, expected %0d", dbg_state, IDLE);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [7:0]  ta [7] = '{8'h80, 8'h80, 8'hC0, 8'hFF, 8'h00, 8'hFF, 8'h80};
        logic [7:0]  tb_ [7] = '{8'h80, 8'hC0, 8'h80, 8'h80, 8'hA5, 8'hFF, 8'hFF};
        logic [12:0] te [7] = '{
            {1'b0, 1'b0, 1'b1, 10'h200},
            {1'b0, 1'b1, 1'b0, 10'h2AA},
            {1'b0, 1'b0, 1'b1, 10'h300},
            {1'b0, 1'b0, 1'b1, 10'h3FC},
            {1'b0, 1'b0, 1'b0, 10'h000},
            {1'b0, 1'b0, 1'b1, 10'h200},
            {1'b0, 1'b1, 1'b0, 10'h202}
        };
        logic [12:0] obs, exp;
        int cyc;
        for (int i = 0; i < 7; i++) begin
            drive_pair(ta[i], tb_[i], te[i], 1'b1);
            collect(1'b0, obs, cyc);
            n_vec++;
            if (cyc != 11) begin
                n_err++;
                $display("FAIL directed_latency[%0d]: got %0d, expected 11", i, cyc);
            end
            exp = exp_q.pop_front();
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL directed_result[%0d] a=%h b=%h: got %h, expected %h",
                         i, ta[i], tb_[i], obs, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_div_zero();
        logic [7:0]  bz [2] = '{8'h00, 8'h7F};
        logic [12:0] obs, exp;
        int cyc;
        for (int i = 0; i < 2; i++) begin
            drive_pair(8'h55, bz[i], {1'b1, 1'b0, 1'b1, 10'h3FF}, 1'b1);
            collect(1'b0, obs, cyc);
            n_vec++;
            if (cyc != 0) begin
                n_err++;
                $display("FAIL divzero_latency[%0d]: got %0d extra edges, expected 0", i, cyc);
            end
            exp = exp_q.pop_front();
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL divzero_result[%0d]: got %h, expected %h", i, obs, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] obs, exp, hold;
        int cyc;
        bus.out_ready = 1'b0;
        drive_pair(8'hC0, 8'h80, {1'b0, 1'b0, 1'b1, 10'h300}, 1'b1);
        collect(1'b1, obs, cyc);
        exp = exp_q.pop_front();
        n_vec++;
        if (obs !== exp || cyc != 11) begin
            n_err++;
            $display("FAIL bp_result: got %h after %0d, expected %h after 11", obs, cyc, exp);
        end
        hold = obs;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = 8'($urandom_range(0, 255));
            bus.b        = 8'($urandom_range(128, 255));
            @(negedge clk);
            n_vec++;
            if ({bus.out_valid, bus.in_ready, obs_now()} !== {1'b1, 1'b0, hold}) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got %h, expected %h", i,
                         {bus.out_valid, bus.in_ready, obs_now()}, {1'b1, 1'b0, hold});
            end
        end
        // Release the result and present the next pair on the same edge.
        bus.in_valid  = 1'b1;
        bus.a         = 8'hFF;
        bus.b         = 8'h80;
        bus.out_ready = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 1'b1, 10'h3FC});
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_in_ready: got %b, expected 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_vec++;
        if (bus.out_valid !== 1'b0 || dbg_state !== BUSY) begin
            n_err++;
            $display("FAIL b2b_accept: out_valid=%b state=%0d, expected 0 and %0d",
                     bus.out_valid, dbg_state, BUSY);
        end
        collect(1'b1, obs, cyc);
        exp = exp_q.pop_front();
        n_vec++;
        if (obs !== exp || cyc != 11) begin
            n_err++;
            $display("FAIL b2b_result: got %h after %0d, expected %h after 11", obs, cyc, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        logic [12:0] obs, exp;
        int cyc;
        int spurious = 0;
        // Abort in BUSY: 5 BUSY edges done, reset lands on the 6th.
        drive_pair(8'h80, 8'hC0, 13'h0, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({bus.out_valid, bus.in_ready, obs_now(), dbg_state} !== {1'b0, 1'b1, 13'h0, IDLE}) begin
            n_err++;
            $display("FAIL busy_reset: got %h, expected %h",
                     {bus.out_valid, bus.in_ready, obs_now(), dbg_state}, {1'b0, 1'b1, 13'h0, IDLE});
        end
        rst = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) spurious++;
        end
        n_vec++;
        if (spurious != 0) begin
            n_err++;
            $display("FAIL busy_reset_spurious: got %0d out_valid cycles, expected 0", spurious);
        end
        // Abort in DONE with the result still held.
        bus.out_ready = 1'b0;
        drive_pair(8'hFF, 8'hFF, 13'h0, 1'b0);
        collect(1'b0, obs, cyc);
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({bus.out_valid, bus.in_ready, obs_now()} !== {1'b0, 1'b1, 13'h0}) begin
            n_err++;
            $display("FAIL done_reset: got %h, expected %h",
                     {bus.out_valid, bus.in_ready, obs_now()}, {1'b0, 1'b1, 13'h0});
        end
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        drive_pair(8'hC0, 8'h80, {1'b0, 1'b0, 1'b1, 10'h300}, 1'b1);
        collect(1'b0, obs, cyc);
        exp = exp_q.pop_front();
        n_vec++;
        if (obs !== exp || cyc != 11) begin
            n_err++;
            $display("FAIL post_reset: got %h after %0d, expected %h after 11", obs, cyc, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [7:0]  a, b;
        logic [12:0] obs, exp;
        int cyc, lat, h;
        for (int i = 0; i < 60; i++) begin
            a = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) b = 8'($urandom_range(0, 127));
            else                           b = 8'($urandom_range(128, 255));
            lat = b[7] ? 11 : 0;
            bus.out_ready = 1'b0;
            drive_pair(a, b, model(a, b), 1'b1);
            collect(1'b1, obs, cyc);
            exp = exp_q.pop_front();
            n_vec++;
            if (obs !== exp || cyc != lat) begin
                n_err++;
                $display("FAIL random[%0d] a=%h b=%h: got %h after %0d, expected %h after %0d",
                         i, a, b, obs, cyc, exp, lat);
            end
            h = $urandom_range(0, 3);
            for (int k = 0; k < h; k++) begin
                @(negedge clk);
                n_vec++;
                if ({bus.out_valid, obs_now()} !== {1'b1, exp}) begin
                    n_err++;
                    $display("FAIL random_hold[%0d]: got %h, expected %h", i,
                             {bus.out_valid, obs_now()}, {1'b1, exp});
                end
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = 8'h00;
        bus.b         = 8'h00;
        bus.out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_directed();
        test_div_zero();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
